// File: rtl/simon_seg_capture.sv
// simon_seg_capture: receive side of the Simon two-digit multiplexed
// seven-segment bus. Synchronizes the pads, applies polarity, waits for each
// {select, segment} pattern to settle, then decodes it into a per-slot hex
// value with valid/blank flags, update/frame/error pulses.
module simon_seg_capture #(
  parameter logic [15:0] STABLE_CYCLES = 16'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segments_in,
  input  logic [1:0] digits_in,
  input  logic       segments_invert,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       valid0,
  output logic       valid1,
  output logic       blank0,
  output logic       blank1,
  output logic       update,
  output logic       update_slot,
  output logic       frame,
  output logic       error
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEEN0 = 2'd1;
  localparam logic [1:0] ST_SEEN1 = 2'd2;

  logic [6:0]  seg_s1, seg_s2;
  logic [1:0]  sel_s1, sel_s2;
  logic        inv_s1, inv_s2;

  logic [8:0]  cur_samp;
  logic [8:0]  prev_samp;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic        commit;

  logic [6:0]  seg;
  logic [1:0]  sel;
  logic [3:0]  dec_val;
  logic        dec_legal;
  logic        dec_blank;

  logic [1:0]  state;

  // Two-flop synchronizers on every pad, including the polarity strap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      sel_s1 <= '0;
      sel_s2 <= '0;
      inv_s1 <= 1'b0;
      inv_s2 <= 1'b0;
    end else begin
      seg_s1 <= segments_in;
      seg_s2 <= seg_s1;
      sel_s1 <= digits_in;
      sel_s2 <= sel_s1;
      inv_s1 <= segments_invert;
      inv_s2 <= inv_s1;
    end
  end

  // Polarity-corrected sample; an invert toggle flips all nine bits
  assign cur_samp = {sel_s2 ^ {2{inv_s2}}, seg_s2 ^ {7{inv_s2}}};
  assign seg      = cur_samp[6:0];
  assign sel      = cur_samp[8:7];

  // Next stability count; commit is flagged on the edge that reaches the
  // threshold so the registered outputs land on that same edge
  always_comb begin
    cnt_next = cnt;
    if (cur_samp != prev_samp) begin
      cnt_next = 16'd1;
    end else if (cnt != STABLE_CYCLES) begin
      cnt_next = cnt + 16'd1;
    end
    commit = (cnt_next == STABLE_CYCLES) && (cnt != STABLE_CYCLES);
  end

  // Stability filter state: previous sample and saturating run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_samp <= '0;
      cnt       <= '0;
    end else begin
      prev_samp <= cur_samp;
      cnt       <= cnt_next;
    end
  end

  // Glyph decode, gfedcba ordering
  always_comb begin
    dec_val   = 4'h0;
    dec_legal = 1'b1;
    dec_blank = (seg == 7'h00);
    case (seg)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  // Commit: write the selected slot, raise pulses, advance the frame tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit0      <= '0;
      digit1      <= '0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
      blank0      <= 1'b0;
      blank1      <= 1'b0;
      update      <= 1'b0;
      update_slot <= 1'b0;
      frame       <= 1'b0;
      error       <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      update <= 1'b0;
      frame  <= 1'b0;
      error  <= 1'b0;
      if (commit) begin
        if (sel == 2'b11) begin
          error <= 1'b1;
        end else if (sel != 2'b00) begin
          update      <= 1'b1;
          update_slot <= sel[1];
          if (!dec_legal && !dec_blank) begin
            error <= 1'b1;
          end
          if (sel[1]) begin
            if (dec_legal) begin
              digit1 <= dec_val;
            end
            valid1 <= dec_legal;
            blank1 <= dec_blank;
          end else begin
            if (dec_legal) begin
              digit0 <= dec_val;
            end
            valid0 <= dec_legal;
            blank0 <= dec_blank;
          end
          case (state)
            ST_IDLE:  state <= sel[1] ? ST_SEEN1 : ST_SEEN0;
            ST_SEEN0: begin
              if (sel[1]) begin
                frame <= 1'b1;
                state <= ST_IDLE;
              end
            end
            ST_SEEN1: begin
              if (!sel[1]) begin
                frame <= 1'b1;
                state <= ST_IDLE;
              end
            end
            default:  state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_simon_seg_capture.sv
// Testbench for simon_seg_capture: glyph table loop, hand-written corner
// sequences, and randomized pad traffic checked every cycle against a
// run-length reference model of the sampled pad history.
module tb_simon_seg_capture;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] segments_in = '0;
  logic [1:0] digits_in = '0;
  logic       segments_invert = 1'b0;
  logic [3:0] digit0, digit1;
  logic       valid0, valid1, blank0, blank1;
  logic       update, update_slot, frame, error;

  always #5 clk = ~clk;

  simon_seg_capture #(.STABLE_CYCLES(16'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .segments_in(segments_in), .digits_in(digits_in),
    .segments_invert(segments_invert),
    .digit0(digit0), .digit1(digit1),
    .valid0(valid0), .valid1(valid1),
    .blank0(blank0), .blank1(blank1),
    .update(update), .update_slot(update_slot),
    .frame(frame), .error(error)
  );

  logic [15:0] act_vec;
  assign act_vec = {digit0, digit1, valid0, valid1, blank0, blank1,
                    update, update_slot, frame, error};

  int    n_vec = 0;
  int    n_bad = 0;
  int    edge_idx = 0;
  int    upd_cnt, frm_cnt, err_cnt, last_upd_edge;
  string phase = "init";

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: pad/sample histories and the expected outputs
  logic [8:0] padq[$];
  logic [8:0] sampq[$];
  logic [3:0] m_d0, m_d1;
  logic       m_v0, m_v1, m_b0, m_b1, m_upd, m_slot, m_frm, m_err;
  logic       seen0, seen1;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] sel;
    logic [3:0] dig;
    logic       val;
    logic       blk;
    logic       err;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s edge %0d: got %h expected %h", phase, name, edge_idx, act, exp);
    end
  endtask

  task automatic model_reset();
    padq.delete();
    sampq.delete();
    edge_idx = 0;
    {m_d0, m_d1, m_v0, m_v1, m_b0, m_b1, m_upd, m_slot, m_frm, m_err} = '0;
    seen0 = 1'b0;
    seen1 = 1'b0;
  endtask

  // One clock edge of the model: the filter sees pads from two edges ago
  // (zeros right after reset) and commits when a run reaches exactly S.
  task automatic model_edge();
    logic [8:0] sv;
    logic [6:0] sg;
    logic [1:0] sl;
    logic [3:0] v;
    logic       found;
    int         run;
    int         i;
    padq.push_back({digits_in ^ {2{segments_invert}}, segments_in ^ {7{segments_invert}}});
    edge_idx++;
    sv = (edge_idx <= 2) ? 9'h000 : padq[edge_idx-3];
    sampq.push_back(sv);
    run = 0;
    i = sampq.size() - 1;
    while (i >= 0 && run <= int'(S) && sampq[i] == sv) begin
      run++;
      i--;
    end
    m_upd = 1'b0;
    m_frm = 1'b0;
    m_err = 1'b0;
    if (run == int'(S)) begin
      sg = sv[6:0];
      sl = sv[8:7];
      if (sl == 2'b11) begin
        m_err = 1'b1;
      end else if (sl != 2'b00) begin
        found = 1'b0;
        v = 4'h0;
        for (int k = 0; k < 16; k++) begin
          if (glyph[k] == sg) begin
            found = 1'b1;
            v = 4'(k);
          end
        end
        m_upd  = 1'b1;
        m_slot = sl[1];
        if (!found && sg != 7'h00) m_err = 1'b1;
        if (sl[1]) begin
          if (found) m_d1 = v;
          m_v1 = found;
          m_b1 = (sg == 7'h00);
          if (seen0) begin m_frm = 1'b1; seen0 = 1'b0; seen1 = 1'b0; end
          else seen1 = 1'b1;
        end else begin
          if (found) m_d0 = v;
          m_v0 = found;
          m_b0 = (sg == 7'h00);
          if (seen1) begin m_frm = 1'b1; seen0 = 1'b0; seen1 = 1'b0; end
          else seen0 = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input logic [6:0] seg, input logic [1:0] sel, input logic inv);
    segments_in     = seg;
    digits_in       = sel;
    segments_invert = inv;
    @(posedge clk);
    #1;
    model_edge();
    check("outputs", act_vec, {m_d0, m_d1, m_v0, m_v1, m_b0, m_b1, m_upd, m_slot, m_frm, m_err});
    if (update) begin upd_cnt++; last_upd_edge = edge_idx; end
    if (frame) frm_cnt++;
    if (error) err_cnt++;
  endtask

  task automatic hold(input logic [6:0] seg, input logic [1:0] sel, input logic inv, input int n);
    for (int i = 0; i < n; i++) cycle(seg, sel, inv);
  endtask

  task automatic tally_clear();
    upd_cnt = 0;
    frm_cnt = 0;
    err_cnt = 0;
    last_upd_edge = -1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", act_vec, 16'h0000);
    model_reset();
    tally_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{7'h3F, 2'b01, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{7'h06, 2'b10, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{7'h5B, 2'b01, 4'h2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{7'h4F, 2'b10, 4'h3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{7'h66, 2'b01, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{7'h6D, 2'b10, 4'h5, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{7'h7D, 2'b01, 4'h6, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{7'h07, 2'b10, 4'h7, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{7'h7F, 2'b01, 4'h8, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{7'h6F, 2'b10, 4'h9, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{7'h77, 2'b01, 4'hA, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{7'h7C, 2'b10, 4'hB, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{7'h39, 2'b01, 4'hC, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{7'h5E, 2'b10, 4'hD, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{7'h79, 2'b01, 4'hE, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{7'h71, 2'b10, 4'hF, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{7'h00, 2'b01, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{7'h00, 2'b10, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{7'h01, 2'b01, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{7'h7E, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1};

    #2;

    // Reset and basic commit
    phase = "basic";
    apply_reset();
    hold(7'h4F, 2'b01, 1'b0, 10);
    check("upd_count", 16'(upd_cnt), 16'd1);
    check("upd_edge", 16'(last_upd_edge), 16'd6);
    check("digit0", 16'(digit0), 16'd3);
    check("valid0", 16'(valid0), 16'd1);
    check("slot_frame", 16'({update_slot, frame}), 16'd0);

    // Multiplexed frame with inverted polarity
    phase = "inverted";
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      hold(~7'h6D, ~2'b10, 1'b1, 8);
      hold(~7'h3F, ~2'b01, 1'b1, 8);
    end
    check("digit1", 16'(digit1), 16'd5);
    check("digit0", 16'(digit0), 16'd0);
    check("valids", 16'({valid0, valid1}), 16'b11);
    check("frames", 16'(frm_cnt), 16'd3);
    check("updates", 16'(upd_cnt), 16'd6);

    // Glitch rejection
    phase = "glitch";
    apply_reset();
    hold(7'h7F, 2'b01, 1'b0, 8);
    hold(7'h06, 2'b01, 1'b0, 3);
    hold(7'h7F, 2'b01, 1'b0, 8);
    check("updates", 16'(upd_cnt), 16'd2);
    check("digit0", 16'(digit0), 16'd8);

    // Blank then undecodable glyph on slot 1
    phase = "blank_bad";
    hold(7'h7C, 2'b10, 1'b0, 8);
    tally_clear();
    hold(7'h00, 2'b10, 1'b0, 8);
    check("blank_flags", 16'({blank1, valid1}), 16'b10);
    check("blank_err", 16'(err_cnt), 16'd0);
    check("blank_upd", 16'(upd_cnt), 16'd1);
    tally_clear();
    hold(7'h01, 2'b10, 1'b0, 8);
    check("bad_flags", 16'({blank1, valid1}), 16'b00);
    check("bad_err", 16'(err_cnt), 16'd1);
    check("bad_digit1", 16'(digit1), 16'hB);

    // Both digits selected: error only, frame tracker untouched
    phase = "both_sel";
    apply_reset();
    hold(7'h3F, 2'b01, 1'b0, 8);
    tally_clear();
    hold(7'h3F, 2'b11, 1'b0, 10);
    check("err", 16'(err_cnt), 16'd1);
    check("upd", 16'(upd_cnt), 16'd0);
    tally_clear();
    hold(7'h06, 2'b10, 1'b0, 8);
    check("frame_after", 16'(frm_cnt), 16'd1);
    check("digit1", 16'(digit1), 16'd1);

    // Reset mid-filter while in SEEN0
    phase = "mid_reset";
    apply_reset();
    hold(7'h4F, 2'b01, 1'b0, 8);
    hold(7'h5B, 2'b10, 1'b0, 5);
    apply_reset();
    hold(7'h5B, 2'b10, 1'b0, 8);
    check("upd", 16'(upd_cnt), 16'd1);
    check("frame", 16'(frm_cnt), 16'd0);
    check("digit1", 16'(digit1), 16'd2);

    // Glyph table
    phase = "table";
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      hold(7'h00, 2'b00, 1'b0, 2);
      tally_clear();
      hold(tbl[i].seg, tbl[i].sel, 1'b0, int'(S) + 3);
      check("tbl_upd", 16'(upd_cnt), 16'd1);
      check("tbl_err", 16'(err_cnt), 16'(tbl[i].err));
      if (tbl[i].sel[1]) begin
        check("tbl_flags1", 16'({valid1, blank1}), 16'({tbl[i].val, tbl[i].blk}));
        if (tbl[i].val) check("tbl_digit1", 16'(digit1), 16'(tbl[i].dig));
      end else begin
        check("tbl_flags0", 16'({valid0, blank0}), 16'({tbl[i].val, tbl[i].blk}));
        if (tbl[i].val) check("tbl_digit0", 16'(digit0), 16'(tbl[i].dig));
      end
    end

    // Randomized traffic against the model
    phase = "random";
    begin
      logic [6:0] rs;
      logic [1:0] rl;
      logic       ri;
      int         r;
      ri = 1'b0;
      for (int n = 0; n < 120; n++) begin
        r = $urandom_range(0, 9);
        if (r < 6) rs = glyph[$urandom_range(0, 15)];
        else if (r == 6) rs = 7'h00;
        else rs = 7'($urandom);
        r = $urandom_range(0, 9);
        rl = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
        if ($urandom_range(0, 9) == 0) ri = ~ri;
        if (ri) hold(~rs, ~rl, ri, $urandom_range(1, 8));
        else hold(rs, rl, ri, $urandom_range(1, 8));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_seg_capture.md
# simon_seg_capture

Receiving end of the Simon game's multiplexed two-digit seven-segment display bus. Samples the segment and digit-select pads, applies the `segments_invert` polarity, and waits for each pattern to settle. It then decodes each settled pattern back to a hex value per digit slot. It provides on-chip loopback checking and the bench-side monitor, so score and level values can be read directly instead of as raw segment patterns.

## Interface
Parameters:
- `STABLE_CYCLES`, default `16'd4`: consecutive identical synchronized samples required before a pattern is committed. Legal range 2..65535.

Ports:
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `segments_in` input, 7 bits: raw segment pads; bit 0 = a … bit 6 = g.
- `digits_in` input, 2 bits: raw digit-select pads; bit 0 = digit 0, bit 1 = digit 1.
- `segments_invert` input, 1 bit: when 1, every segment bit and every digit-select bit is active-low on the pads.
- `digit0`, `digit1` output, 4 bits each: last decoded hex value per slot.
- `valid0`, `valid1` output, 1 bit each: the slot's last committed pattern was a legal hex glyph.
- `blank0`, `blank1` output, 1 bit each: the slot's last committed pattern was all segments off.
- `update` output, 1 bit: one-cycle pulse when a slot is committed.
- `update_slot` output, 1 bit: the slot written by the current `update`; holds its value otherwise.
- `frame` output, 1 bit: one-cycle pulse when both slots have been committed since the last `frame`.
- `error` output, 1 bit: one-cycle pulse on a commit with both digits selected, or with an undecodable glyph.

## Operation
- **Input synchronization:** `segments_in`, `digits_in` and `segments_invert` each pass through a 2-flop synchronizer.
- **Polarity:** `seg = sync_seg ^ {7{inv}}` and `sel = sync_sel ^ {2{inv}}`.
- **Stability filter:**
  - Register the previous `{sel,seg}` and hold a 16-bit counter `cnt`.
  - If the current sample differs from the previous one, `cnt` is set to 1.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES`.
  - A commit occurs only on the transition of `cnt` to `STABLE_CYCLES`, so exactly once per stable period.
- **Commit by `sel` value:**
  - `2'b00`: nothing is committed and no pulse is produced.
  - `2'b01`: slot 0 is written.
  - `2'b10`: slot 1 is written.
  - `2'b11`: `error` pulses; no slot, flag or frame state changes.
- **Decode of `seg` (encoded as gfedcba):**
  - Legal glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Legal glyph: `digitN` is set to the value, `validN=1`, `blankN=0`.
  - `7'h00`: `digitN` holds, `validN=0`, `blankN=1`.
  - Any other pattern: `digitN` holds, `validN=0`, `blankN=0`, and `error` pulses.
  - `update` pulses for every slot commit, including blank and undecodable ones.
- **Frame FSM:**
  - States: `IDLE` (neither slot seen), `SEEN0`, `SEEN1`.
  - From `IDLE`: a slot-0 commit goes to `SEEN0`; a slot-1 commit goes to `SEEN1`.
  - From `SEEN0`: a slot-1 commit pulses `frame` and returns to `IDLE`.
  - From `SEEN1`: a slot-0 commit pulses `frame` and returns to `IDLE`.
  - Repeated commits of the already-seen slot leave the state unchanged.
  - `2'b11` commits do not change the state.
- **Reset:**
  - Outputs: all 0, i.e. `digit0=digit1=0`, all valid/blank flags 0, `update`, `update_slot`, `frame` and `error` all 0.
  - Internal: synchronizers and the previous-sample register are 0, `cnt=0`, FSM in `IDLE`.
  - Reset asserted mid-filter aborts the pending commit.
  - After release, the filter starts counting from the first post-reset sample.

## Timing
- **Sample index:** a pad value captured by the first synchronizer flop at edge N is sample 1 at edge N+1.
- **Commit latency:** if the value is held, sample `STABLE_CYCLES` occurs at edge N+`STABLE_CYCLES`. The commit registers at edge N+`STABLE_CYCLES`+1; `update`, the slot outputs, `frame` and `error` are valid from that edge for one cycle.
- **Output registration:** all outputs are registered; there is no combinational path from any input.
- **Mid-filter change:** a change on any of the 9 bits restarts the count; a glitch shorter than `STABLE_CYCLES` samples never commits.
- **Polarity change:** a toggle of `segments_invert` changes every sampled bit, so it restarts the filter like any other change.
- **Long hold:** a value held indefinitely commits exactly once.
- **Re-commit:** a new commit of the same slot requires an intervening change, such as the normal digit-select alternation.
- **Simultaneous pulses:** `update`, `frame` and `error` may pulse in the same cycle; for example, a slot commit with an undecodable glyph that completes a frame pulses all three.

## Test plan
- **Reset and basic commit:** with `STABLE_CYCLES=4` and `inv=0`, hold `seg=7'h4F`, `sel=2'b01` for 10 cycles. Required: `update` pulses exactly once, 5 edges after the capturing edge; `digit0=3`, `valid0=1`, `update_slot=0`, `frame=0`.
- **Multiplexed frame, inverted polarity:** with `inv=1`, alternate 8 cycles of `sel=~2'b10`, `seg=~7'h6D` with 8 cycles of `sel=~2'b01`, `seg=~7'h3F`. Required: `digit1=5`, `digit0=0`, both valid, and `frame` pulses once per pair of commits.
- **Glitch rejection:** a stable `digit0=8` is followed by a 3-cycle `seg=7'h06` glitch with `STABLE_CYCLES=4`, then returns to `7'h7F`. Required: no commit for the glitch; `digit0` stays 8.
- **Blank and bad glyph:** commit `7'h00` to slot 1, then `7'h01` to slot 1. Required: first commit gives `blank1=1`, `valid1=0`, no `error`; second gives `blank1=0`, `valid1=0`, one `error` pulse, `digit1` unchanged.
- **Both digits selected:** hold `sel=2'b11` stable. Required: one `error` pulse, no `update`, FSM state unchanged.
- **Reset mid-operation:** assert `rst_n=0` asynchronously at count 3 of 4 in state `SEEN0`. Required: all outputs are 0 immediately; after release, a stable slot-1 value commits without pulsing `frame`.
